// File: rtl/feature_pool2x2_if.sv
`default_nettype none
// ============================================================================
// Module  : feature_pool2x2_if
// Brief   : Pixel-stream bundle (input and pooled output) for feature_pool2x2.
// Rev     : 1.0 - initial release
// ============================================================================
interface feature_pool2x2_if #(
    parameter int V_BITW     = 1,
    parameter int H_BITW     = 2,
    parameter int UNITS      = 12,
    parameter int FIXED_BITW = 13
);
    logic                          in_enable;
    logic [0:FIXED_BITW*UNITS-1]   in_pixels;
    logic [V_BITW-1:0]             in_vcnt;
    logic [H_BITW-1:0]             in_hcnt;
    logic                          out_enable;
    logic [0:FIXED_BITW*UNITS-1]   out_pixels;
    logic [V_BITW-1:0]             out_vcnt;
    logic [H_BITW-1:0]             out_hcnt;

    modport master (
        output in_enable, in_pixels, in_vcnt, in_hcnt,
        input  out_enable, out_pixels, out_vcnt, out_hcnt
    );

    modport slave (
        input  in_enable, in_pixels, in_vcnt, in_hcnt,
        output out_enable, out_pixels, out_vcnt, out_hcnt
    );
endinterface
`default_nettype wire

// File: rtl/feature_pool2x2.sv
`default_nettype none
// ============================================================================
// Module  : feature_pool2x2
// Brief   : 2x2 stride-2 per-unit pooling of a vcnt/hcnt-tagged feature
//           stream. Max pooling by default; FEATURE_POOL_AVG_EN selects
//           floor-average pooling.
// Rev     : 1.0 - initial release
// ============================================================================
module feature_pool2x2 #(
    parameter int HEIGHT     = -1,
    parameter int WIDTH      = -1,
    parameter int W_HEIGHT   = -1,
    parameter int W_WIDTH    = -1,
    parameter int UNITS      = 12,
    parameter int FIXED_BITW = 13
) (
    input wire logic          clock,
    input wire logic          n_rst,
    feature_pool2x2_if.slave  bus
);
    localparam int V_BITW     = (W_HEIGHT > 1) ? $clog2(W_HEIGHT) : 1;
    localparam int H_BITW     = (W_WIDTH > 2) ? $clog2(W_WIDTH) : 2;
    localparam int C_PIX_W    = FIXED_BITW * UNITS;
`ifdef FEATURE_POOL_AVG_EN
    localparam int C_LB_UW    = FIXED_BITW + 1;
`else
    localparam int C_LB_UW    = FIXED_BITW;
`endif
    localparam int C_LB_W     = C_LB_UW * UNITS;
    localparam int C_LB_DEPTH = (W_WIDTH > 2) ? (W_WIDTH + 1) / 2 : 2;
    // An odd trailing row/column is never paired, so it is treated as a bubble.
    localparam int C_ACT_H    = (HEIGHT / 2) * 2;
    localparam int C_ACT_W    = (WIDTH / 2) * 2;

    logic                  w_in_act;
    logic                  r1_act;
    logic [0:C_PIX_W-1]    r1_pix;
    logic [V_BITW-1:0]     r1_vcnt;
    logic [H_BITW-1:0]     r1_hcnt;

    logic [0:C_PIX_W-1]    r_hold;
    logic [0:C_LB_W-1]     w_hval;
    logic                  r2_act;
    logic [0:C_LB_W-1]     r2_hval;
    logic [V_BITW-1:0]     r2_vcnt;
    logic [H_BITW-1:0]     r2_hcnt;

    logic [0:C_LB_W-1]     r_lb_mem [C_LB_DEPTH];
    logic [C_LB_DEPTH-1:0] r_flag;
    logic [H_BITW-2:0]     w_idx;
    logic                  r3_fire;
    logic [0:C_LB_W-1]     r3_lb;
    logic [0:C_LB_W-1]     r3_hval;
    logic [V_BITW-1:0]     r3_vcnt;
    logic [H_BITW-1:0]     r3_hcnt;
    logic [0:C_PIX_W-1]    w_vval;

    assign w_in_act = bus.in_enable
                   && (int'(bus.in_vcnt) < C_ACT_H)
                   && (int'(bus.in_hcnt) < C_ACT_W);
    assign w_idx    = r2_hcnt[H_BITW-1:1];

    for (genvar u = 0; u < UNITS; u++) begin : g_unit
        logic signed [FIXED_BITW-1:0] w_hold_u;
        logic signed [FIXED_BITW-1:0] w_cur_u;
        logic signed [C_LB_UW-1:0]    w_lb_u;
        logic signed [C_LB_UW-1:0]    w_h_u;

        assign w_hold_u = r_hold[u*FIXED_BITW +: FIXED_BITW];
        assign w_cur_u  = r1_pix[u*FIXED_BITW +: FIXED_BITW];
        assign w_lb_u   = r3_lb[u*C_LB_UW +: C_LB_UW];
        assign w_h_u    = r3_hval[u*C_LB_UW +: C_LB_UW];
`ifdef FEATURE_POOL_AVG_EN
        logic signed [FIXED_BITW+1:0] w_sum_u;
        logic [1:0]                   w_unused_frac;

        assign w_hval[u*C_LB_UW +: C_LB_UW] = {w_hold_u[FIXED_BITW-1], w_hold_u}
                                            + {w_cur_u[FIXED_BITW-1], w_cur_u};
        assign w_sum_u = {w_lb_u[C_LB_UW-1], w_lb_u} + {w_h_u[C_LB_UW-1], w_h_u};
        // Dropping the two LSBs of the sign-extended sum is a floor divide by 4.
        assign {w_vval[u*FIXED_BITW +: FIXED_BITW], w_unused_frac} = w_sum_u;
`else
        assign w_hval[u*C_LB_UW +: C_LB_UW] = (w_hold_u >= w_cur_u) ? w_hold_u : w_cur_u;
        assign w_vval[u*FIXED_BITW +: FIXED_BITW] = (w_lb_u >= w_h_u) ? w_lb_u : w_h_u;
`endif
    end

    always_ff @(posedge clock) begin
        if (n_rst) begin
            r1_act  <= 1'b0;
            r1_pix  <= '0;
            r1_vcnt <= '0;
            r1_hcnt <= '0;
        end else begin
            r1_act <= w_in_act;
            if (w_in_act) begin
                r1_pix  <= bus.in_pixels;
                r1_vcnt <= bus.in_vcnt;
                r1_hcnt <= bus.in_hcnt;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (n_rst) begin
            r_hold  <= '0;
            r2_act  <= 1'b0;
            r2_hval <= '0;
            r2_vcnt <= '0;
            r2_hcnt <= '0;
        end else begin
            r2_act <= r1_act & r1_hcnt[0];
            if (r1_act) begin
                if (!r1_hcnt[0]) begin
                    r_hold <= r1_pix;
                end else begin
                    r2_hval <= w_hval;
                    r2_vcnt <= r1_vcnt;
                    r2_hcnt <= r1_hcnt;
                end
            end
        end
    end

    // Line buffer storage carries no reset; validity lives in r_flag.
    always_ff @(posedge clock) begin
        if (r2_act && !r2_vcnt[0]) begin
            r_lb_mem[w_idx] <= r2_hval;
        end
    end

    always_ff @(posedge clock) begin
        if (n_rst) begin
            r_flag  <= '0;
            r3_fire <= 1'b0;
            r3_lb   <= '0;
            r3_hval <= '0;
            r3_vcnt <= '0;
            r3_hcnt <= '0;
        end else begin
            r3_fire <= 1'b0;
            if (r2_act) begin
                if (!r2_vcnt[0]) begin
                    r_flag[w_idx] <= 1'b1;
                end else begin
                    r_flag[w_idx] <= 1'b0;
                    r3_fire       <= r_flag[w_idx];
                    r3_lb         <= r_lb_mem[w_idx];
                    r3_hval       <= r2_hval;
                    r3_vcnt       <= r2_vcnt;
                    r3_hcnt       <= r2_hcnt;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (n_rst) begin
            bus.out_enable <= 1'b0;
            bus.out_pixels <= '0;
            bus.out_vcnt   <= '0;
            bus.out_hcnt   <= '0;
        end else begin
            bus.out_enable <= r3_fire;
            if (r3_fire) begin
                bus.out_pixels <= w_vval;
                bus.out_vcnt   <= r3_vcnt >> 1;
                bus.out_hcnt   <= r3_hcnt >> 1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_feature_pool2x2.sv
`default_nettype none
// ============================================================================
// Module  : tb_feature_pool2x2
// Brief   : Scoreboard bench for feature_pool2x2 on a 5x5 image in an 8x8
//           window (odd last row/column must be dropped).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_feature_pool2x2;
    localparam int HEIGHT     = 5;
    localparam int WIDTH      = 5;
    localparam int W_HEIGHT   = 8;
    localparam int W_WIDTH    = 8;
    localparam int UNITS      = 12;
    localparam int FIXED_BITW = 13;
    localparam int V_BITW     = $clog2(W_HEIGHT);
    localparam int H_BITW     = $clog2(W_WIDTH);
    localparam int C_PIX_W    = FIXED_BITW * UNITS;

    typedef logic [0:C_PIX_W-1] pix_t;
    typedef struct {
        pix_t pix;
        int   v;
        int   h;
        int   due;
        int   hand_u0;
        int   hand_u11;
        bit   has_u11;
    } exp_t;

`ifdef FEATURE_POOL_AVG_EN
    localparam int C_HAND_U0 [4] = '{640, 1152, 2688, 3200};
    localparam int C_HAND_U11    = -832;
`else
    localparam int C_HAND_U0 [4] = '{1280, 1792, 3328, 3840};
    localparam int C_HAND_U11    = -256;
`endif

    logic clock = 1'b0;
    logic n_rst = 1'b1;
    logic rst_q = 1'b1;
    int   cyc   = 0;
    int   nvec  = 0;
    int   nerr  = 0;
    bit   mon_en = 1'b0;
    logic [1:0] flags = '0;
    exp_t sb[$];
    exp_t m_e;
    pix_t last_pix = '0;
    int   last_v = 0;
    int   last_h = 0;

    feature_pool2x2_if #(
        .V_BITW(V_BITW), .H_BITW(H_BITW), .UNITS(UNITS), .FIXED_BITW(FIXED_BITW)
    ) bus ();

    feature_pool2x2 #(
        .HEIGHT(HEIGHT), .WIDTH(WIDTH), .W_HEIGHT(W_HEIGHT), .W_WIDTH(W_WIDTH),
        .UNITS(UNITS), .FIXED_BITW(FIXED_BITW)
    ) dut (
        .clock (clock),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_q <= n_rst;
    end

    // Unit 0 ramps over the 4x4 pooled area; unit 11 carries a negative block.
    function automatic int unit_val(int f, int v, int h, int u);
        if (v >= HEIGHT || h >= WIDTH) return 4095;
        if (u == 0) return (v < 4 && h < 4) ? (h + 4 * v) * 256 : 4095;
        if (u == 11 && v < 2 && h < 2) begin
            case (v * 2 + h)
                0:       return -768;
                1:       return -256;
                2:       return -1792;
                default: return -512;
            endcase
        end
        return ((u * 13 + v * 7 + h * 5 + f * 3) % 31 - 15) * 97;
    endfunction

    function automatic pix_t make_pix(int f, int v, int h);
        pix_t p;
        p = '0;
        for (int u = 0; u < UNITS; u++) begin
            p[u*FIXED_BITW +: FIXED_BITW] = FIXED_BITW'(unit_val(f, v, h, u));
        end
        return p;
    endfunction

    function automatic int pool4(int a, int b, int c, int d);
`ifdef FEATURE_POOL_AVG_EN
        return (a + b + c + d) >>> 2;
`else
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic drive(input logic en, input int f, input int v, input int h, input logic rst);
        exp_t e;
        @(posedge clock);
        #1;
        n_rst         = rst;
        bus.in_enable = en;
        bus.in_vcnt   = V_BITW'(v);
        bus.in_hcnt   = H_BITW'(h);
        bus.in_pixels = make_pix(en ? f : f + 7, v, h);
        if (rst) begin
            flags = '0;
            while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        end else if (en && v < 4 && h < 4 && (h % 2) == 1) begin
            if ((v % 2) == 0) begin
                flags[h/2] = 1'b1;
            end else begin
                if (flags[h/2]) begin
                    for (int u = 0; u < UNITS; u++) begin
                        e.pix[u*FIXED_BITW +: FIXED_BITW] = FIXED_BITW'(pool4(
                            unit_val(f, v-1, h-1, u), unit_val(f, v-1, h, u),
                            unit_val(f, v, h-1, u),   unit_val(f, v, h, u)));
                    end
                    e.v        = v / 2;
                    e.h        = h / 2;
                    e.due      = cyc + 4;
                    e.hand_u0  = C_HAND_U0[(v/2)*2 + h/2];
                    e.hand_u11 = C_HAND_U11;
                    e.has_u11  = (v == 1 && h == 1);
                    sb.push_back(e);
                end
                flags[h/2] = 1'b0;
            end
        end
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            if (rst_q) begin
                last_pix = '0;
                last_v   = 0;
                last_h   = 0;
            end
            if (bus.out_enable === 1'b1) begin
                if (sb.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL strobe: got out_enable=1 at cycle %0d, required 0", cyc);
                end else begin
                    m_e = sb.pop_front();
                    chk("latency", cyc, m_e.due);
                    chk("out_vcnt", int'(bus.out_vcnt), m_e.v);
                    chk("out_hcnt", int'(bus.out_hcnt), m_e.h);
                    nvec++;
                    if (bus.out_pixels !== m_e.pix) begin
                        nerr++;
                        $display("FAIL out_pixels: got %h, required %h", bus.out_pixels, m_e.pix);
                    end
                    chk("unit0", int'($signed(bus.out_pixels[0 +: FIXED_BITW])), m_e.hand_u0);
                    if (m_e.has_u11) begin
                        chk("unit11", int'($signed(bus.out_pixels[11*FIXED_BITW +: FIXED_BITW])),
                            m_e.hand_u11);
                    end
                    last_pix = m_e.pix;
                    last_v   = m_e.v;
                    last_h   = m_e.h;
                end
            end else begin
                nvec++;
                if (bus.out_enable !== 1'b0 || bus.out_pixels !== last_pix
                    || bus.out_vcnt !== V_BITW'(last_v) || bus.out_hcnt !== H_BITW'(last_h)) begin
                    nerr++;
                    $display("FAIL idle_hold: got en=%b v=%0d h=%0d pix=%h, required en=0 v=%0d h=%0d pix=%h",
                             bus.out_enable, bus.out_vcnt, bus.out_hcnt, bus.out_pixels,
                             last_v, last_h, last_pix);
                end
                if (sb.size() > 0 && cyc > sb[0].due) begin
                    m_e = sb.pop_front();
                    nvec++;
                    nerr++;
                    $display("FAIL missing_strobe: got none by cycle %0d, required one at %0d (row %0d col %0d)",
                             cyc, m_e.due, m_e.v, m_e.h);
                end
            end
        end
    end

    initial begin
        bus.in_enable = 1'b0;
        bus.in_pixels = '0;
        bus.in_vcnt   = '0;
        bus.in_hcnt   = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_enable", int'(bus.out_enable), 0);
        chk("rst_out_pixels_zero", int'(bus.out_pixels == '0), 1);
        chk("rst_out_vcnt", int'(bus.out_vcnt), 0);
        chk("rst_out_hcnt", int'(bus.out_hcnt), 0);
        mon_en = 1'b1;
        // Frame 0 plain, 1 with a reset mid row 1, 2 plain, 3 with enable gaps.
        for (int f = 0; f < 4; f++) begin
            for (int v = 0; v < W_HEIGHT; v++) begin
                for (int h = 0; h < W_WIDTH; h++) begin
                    drive(1'b1, f, v, h, (f == 1 && v == 1 && h == 2));
                    if (f == 3 && v < 2 && h == 2) begin
                        repeat (3) drive(1'b0, f, v, 2, 1'b0);
                    end
                end
            end
        end
        repeat (10) drive(1'b0, 0, 0, 0, 1'b0);
        chk("scoreboard_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #100000;
        nvec++;
        nerr++;
        $display("FAIL watchdog: got no completion by time %0t, required finish", $time);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
`default_nettype wire
